// File: rtl/cache_miss_controller_if.sv
// Bundles the CPU load port, cache array port and memory fetch port of the miss controller.
// master = controller side, slave = the CPU/array/memory environment.
interface cache_miss_controller_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned WORD_COUNT = 4,
    parameter int unsigned CNT_WIDTH  = 16
);
    localparam int unsigned LINE_W = WORD_SIZE * WORD_COUNT;
    localparam int unsigned MEM_AW = ADDR_WIDTH - $clog2(WORD_COUNT);

    // CPU load port
    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_ready;
    logic                  cpu_valid;
    logic [WORD_SIZE-1:0]  cpu_data;

    // cache array port
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic                  cache_read;
    logic [LINE_W-1:0]     cache_fill_data;
    logic                  cache_hit;
    logic [WORD_SIZE-1:0]  cache_data;

    // memory line fetch port
    logic                  mem_req;
    logic [MEM_AW-1:0]     mem_addr;
    logic                  mem_ack;
    logic [WORD_SIZE-1:0]  mem_data;

    // statistics
    logic [CNT_WIDTH-1:0]  hit_count;
    logic [CNT_WIDTH-1:0]  miss_count;

    modport master (
        input  cpu_req, cpu_addr, cache_hit, cache_data, mem_ack, mem_data,
        output cpu_ready, cpu_valid, cpu_data, cache_addr, cache_read, cache_fill_data,
               mem_req, mem_addr, hit_count, miss_count
    );

    modport slave (
        output cpu_req, cpu_addr, cache_hit, cache_data, mem_ack, mem_data,
        input  cpu_ready, cpu_valid, cpu_data, cache_addr, cache_read, cache_fill_data,
               mem_req, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/cache_miss_controller.sv
// Single-outstanding read controller for a direct-mapped cache: lookup, line fetch on miss,
// one-cycle line fill, word return, and saturating hit/miss statistics. All outputs registered.
module cache_miss_controller #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned WORD_COUNT = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_miss_controller_if.master bus
);
    localparam int unsigned OFF_W     = $clog2(WORD_COUNT);
    localparam int unsigned MEM_AW    = ADDR_WIDTH - OFF_W;
    localparam int unsigned LINE_W    = WORD_SIZE * WORD_COUNT;
    localparam int unsigned LAST_BEAT = WORD_COUNT - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        FETCH,
        FILL,
        RESPOND
    } state_t;

    state_t                               state,     state_nx;
    logic [ADDR_WIDTH-1:0]                addr_q,    addr_nx;
    logic [WORD_COUNT-1:0][WORD_SIZE-1:0] line_q,    line_nx;
    logic [OFF_W-1:0]                     beat_q,    beat_nx;
    logic                                 ready_q,   ready_nx;
    logic                                 valid_q,   valid_nx;
    logic [WORD_SIZE-1:0]                 data_q,    data_nx;
    logic                                 read_q,    read_nx;
    logic [LINE_W-1:0]                    fill_q,    fill_nx;
    logic                                 mreq_q,    mreq_nx;
    logic [MEM_AW-1:0]                    maddr_q,   maddr_nx;
    logic [CNT_WIDTH-1:0]                 hits_q,    hits_nx;
    logic [CNT_WIDTH-1:0]                 misses_q,  misses_nx;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // next-state and next-output logic
    always_comb begin
        state_nx  = state;
        addr_nx   = addr_q;
        line_nx   = line_q;
        beat_nx   = beat_q;
        valid_nx  = 1'b0;
        data_nx   = data_q;
        fill_nx   = fill_q;
        mreq_nx   = mreq_q;
        maddr_nx  = maddr_q;
        hits_nx   = hits_q;
        misses_nx = misses_q;

        case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    addr_nx  = bus.cpu_addr;
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                state_nx = CHECK;
            end
            CHECK: begin
                if (bus.cache_hit) begin
                    data_nx  = bus.cache_data;
                    hits_nx  = sat_inc(hits_q);
                    state_nx = RESPOND;
                end else begin
                    misses_nx = sat_inc(misses_q);
                    mreq_nx   = 1'b1;
                    maddr_nx  = addr_q[ADDR_WIDTH-1:OFF_W];
                    beat_nx   = '0;
                    state_nx  = FETCH;
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    line_nx[beat_q] = bus.mem_data;
                    beat_nx         = beat_q + OFF_W'(1);
                    // last beat: the fill image already includes the word arriving now
                    if (beat_q == OFF_W'(LAST_BEAT)) begin
                        mreq_nx  = 1'b0;
                        fill_nx  = line_nx;
                        state_nx = FILL;
                    end
                end
            end
            FILL: begin
                data_nx  = line_q[addr_q[OFF_W-1:0]];
                state_nx = RESPOND;
            end
            RESPOND: begin
                valid_nx = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        ready_nx = (state_nx == IDLE);
        read_nx  = (state_nx != FILL);
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            line_q   <= '0;
            beat_q   <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            data_q   <= '0;
            read_q   <= 1'b1;
            fill_q   <= '0;
            mreq_q   <= 1'b0;
            maddr_q  <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            state    <= state_nx;
            addr_q   <= addr_nx;
            line_q   <= line_nx;
            beat_q   <= beat_nx;
            ready_q  <= ready_nx;
            valid_q  <= valid_nx;
            data_q   <= data_nx;
            read_q   <= read_nx;
            fill_q   <= fill_nx;
            mreq_q   <= mreq_nx;
            maddr_q  <= maddr_nx;
            hits_q   <= hits_nx;
            misses_q <= misses_nx;
        end
    end

    assign bus.cpu_ready       = ready_q;
    assign bus.cpu_valid       = valid_q;
    assign bus.cpu_data        = data_q;
    assign bus.cache_addr      = addr_q;
    assign bus.cache_read      = read_q;
    assign bus.cache_fill_data = fill_q;
    assign bus.mem_req         = mreq_q;
    assign bus.mem_addr        = maddr_q;
    assign bus.hit_count       = hits_q;
    assign bus.miss_count      = misses_q;
endmodule

// File: tb/tb_cache_miss_controller.sv
// Scoreboard bench for cache_miss_controller: array and memory models, abstract cache model,
// and a narrow-counter twin running in lockstep to reach counter saturation quickly.
module tb_cache_miss_controller;
    localparam int unsigned AW   = 15;
    localparam int unsigned WS   = 32;
    localparam int unsigned WC   = 4;
    localparam int unsigned CW   = 16;
    localparam int unsigned CW_S = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_miss_controller_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .WORD_COUNT(WC), .CNT_WIDTH(CW))   bus ();
    cache_miss_controller_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .WORD_COUNT(WC), .CNT_WIDTH(CW_S)) bus_s ();

    cache_miss_controller #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .WORD_COUNT(WC), .CNT_WIDTH(CW))
        dut (.clk(clk), .rst(rst), .bus(bus));
    cache_miss_controller #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .WORD_COUNT(WC), .CNT_WIDTH(CW_S))
        dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    assign bus_s.cpu_req    = bus.cpu_req;
    assign bus_s.cpu_addr   = bus.cpu_addr;
    assign bus_s.cache_hit  = bus.cache_hit;
    assign bus_s.cache_data = bus.cache_data;
    assign bus_s.mem_ack    = bus.mem_ack;
    assign bus_s.mem_data   = bus.mem_data;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WS-1:0]    data;
        bit               hit;
        int               lat;
        longint           acc;
        logic [WS*WC-1:0] line;
        int               hits;
        int               misses;
    } exp_t;

    exp_t        sb[$];
    bit          ack_pat[$];
    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    int          hits_raw = 0;
    int          misses_raw = 0;
    bit          m_vld [1024];
    logic [2:0]  m_tag [1024];
    int          u_idx;
    bit          u_vld;
    logic [2:0]  u_tag;
    logic [31:0] mem_ovr [int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
        if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic longint sat(input int raw, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (longint'(raw) > m) ? m : longint'(raw);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // cache array: lookup result registered one cycle after the lookup edge, line write when read=0
    logic             arr_vld  [1024];
    logic [2:0]       arr_tag  [1024];
    logic [WS*WC-1:0] arr_line [1024];
    wire  [9:0]       a_idx = bus.cache_addr[11:2];
    wire  [1:0]       a_off = bus.cache_addr[1:0];

    always @(posedge clk) begin
        if (bus.cache_read === 1'b0) begin
            arr_vld[a_idx]  <= 1'b1;
            arr_tag[a_idx]  <= bus.cache_addr[14:12];
            arr_line[a_idx] <= bus.cache_fill_data;
        end else begin
            bus.cache_hit  <= arr_vld[a_idx] && (arr_tag[a_idx] == bus.cache_addr[14:12]);
            bus.cache_data <= arr_line[a_idx][a_off*32 +: 32];
        end
    end

    // memory responder: follows the queued ack pattern while mem_req is up, junk acks otherwise
    int rbeat = 0;
    bit r_ack;
    always @(posedge clk) begin
        #2;
        if (rst || !bus.mem_req) begin
            rbeat        = 0;
            bus.mem_ack  = ($urandom_range(0, 3) == 0);
            bus.mem_data = $urandom;
        end else begin
            r_ack = 1'b1;
            if (ack_pat.size() > 0) r_ack = ack_pat.pop_front();
            bus.mem_ack  = r_ack;
            bus.mem_data = r_ack ? mem_val({bus.mem_addr, 2'(rbeat)}) : $urandom;
            if (r_ack) rbeat++;
        end
    end

    // monitor: pops one expectation per cpu_valid pulse
    int   fills = 0;
    bit   mreq_d = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (rst) begin
            fills  = 0;
            mreq_d = 1'b0;
        end else begin
            if (bus.cache_read === 1'b0) begin
                fills++;
                chk("fill_pending", 128'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    chk("fill_on_miss", 128'(sb[0].hit), 0);
                    chk("fill_data", bus.cache_fill_data, sb[0].line);
                end
            end
            if (bus.mem_req && !mreq_d) begin
                chk("mem_req_pending", 128'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    chk("mem_req_on_miss", 128'(sb[0].hit), 0);
                    chk("mem_addr", 128'(bus.mem_addr), 128'(sb[0].addr[14:2]));
                end
            end
            mreq_d = bus.mem_req;
            if (bus.cpu_valid) begin
                chk("valid_pending", 128'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    me = sb.pop_front();
                    chk("cpu_data", 128'(bus.cpu_data), 128'(me.data));
                    chk("latency", 128'(cyc - me.acc), 128'(me.lat));
                    chk("fill_cycles", 128'(fills), me.hit ? 128'(0) : 128'(1));
                    chk("hit_count", 128'(bus.hit_count), 128'(sat(me.hits, CW)));
                    chk("miss_count", 128'(bus.miss_count), 128'(sat(me.misses, CW)));
                    chk("narrow_data", 128'(bus_s.cpu_data), 128'(me.data));
                    chk("narrow_hit_count", 128'(bus_s.hit_count), 128'(sat(me.hits, CW_S)));
                    chk("narrow_miss_count", 128'(bus_s.miss_count), 128'(sat(me.misses, CW_S)));
                end
                fills = 0;
            end
        end
    end

    // mode: 0 back-to-back acks, 1 pattern 1001101, 2 random stalls, 3 two beats then a long stall
    task automatic issue(input logic [AW-1:0] a, input bit hold, input int mode);
        exp_t e;
        int   n;
        int   idx;
        n   = 0;
        idx = int'(a[11:2]);
        do begin
            @(posedge clk); #2;
            n++;
        end while (!bus.cpu_ready && n < 300);
        chk("ready_wait", 128'(bus.cpu_ready), 1);
        if (!bus.cpu_ready) return;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        e.addr = a;
        e.data = mem_val(a);
        e.hit  = m_vld[idx] && (m_tag[idx] == a[14:12]);
        for (int k = 0; k < 4; k++) e.line[k*32 +: 32] = mem_val({a[14:2], 2'(k)});
        ack_pat.delete();
        if (e.hit) begin
            hits_raw++;
            e.lat = 3;
        end else begin
            misses_raw++;
            case (mode)
                0: for (int k = 0; k < 4; k++) ack_pat.push_back(1'b1);
                1: ack_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
                2: for (int k = 0; k < 4; k++) begin
                       for (int s = $urandom_range(0, 2); s > 0; s--) ack_pat.push_back(1'b0);
                       ack_pat.push_back(1'b1);
                   end
                default: begin
                    ack_pat.push_back(1'b1);
                    ack_pat.push_back(1'b1);
                    for (int k = 0; k < 40; k++) ack_pat.push_back(1'b0);
                end
            endcase
            e.lat = 4 + ack_pat.size();
            u_idx = idx;
            u_vld = m_vld[idx];
            u_tag = m_tag[idx];
            m_vld[idx] = 1'b1;
            m_tag[idx] = a[14:12];
        end
        e.hits   = hits_raw;
        e.misses = misses_raw;
        @(posedge clk); #1;
        e.acc = cyc;
        sb.push_back(e);
        chk("ready_drop", 128'(bus.cpu_ready), 0);
        if (!hold) bus.cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] ra;
    int            n_wait;
    initial begin
        for (int i = 0; i < 1024; i++) begin
            arr_vld[i] = 1'b0;
            arr_tag[i] = '0;
            arr_line[i] = '0;
            m_vld[i] = 1'b0;
            m_tag[i] = '0;
        end
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;
        mem_ovr[4] = 32'h11;
        mem_ovr[5] = 32'h22;
        mem_ovr[6] = 32'h33;
        mem_ovr[7] = 32'h44;

        #1 rst = 1'b1;
        #2;
        chk("rst_cpu_ready", 128'(bus.cpu_ready), 1);
        chk("rst_cache_read", 128'(bus.cache_read), 1);
        chk("rst_cpu_valid", 128'(bus.cpu_valid), 0);
        chk("rst_cpu_data", 128'(bus.cpu_data), 0);
        chk("rst_mem_req", 128'(bus.mem_req), 0);
        chk("rst_mem_addr", 128'(bus.mem_addr), 0);
        chk("rst_cache_addr", 128'(bus.cache_addr), 0);
        chk("rst_fill_data", bus.cache_fill_data, 0);
        chk("rst_hit_count", 128'(bus.hit_count), 0);
        chk("rst_miss_count", 128'(bus.miss_count), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        issue(15'h0005, 1'b0, 0);           // cold miss, line {44,33,22,11}
        issue(15'h0005, 1'b0, 0);           // same word now hits
        issue(15'h1234, 1'b0, 1);           // miss with stalled acks
        issue(15'h2100, 1'b1, 2);           // request held through a miss
        issue(15'h2102, 1'b0, 0);           // accepted only after return to idle

        issue(15'h3008, 1'b0, 3);           // reset after two beats
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_req", 128'(bus.mem_req), 0);
        chk("abort_cpu_ready", 128'(bus.cpu_ready), 1);
        chk("abort_cache_read", 128'(bus.cache_read), 1);
        chk("abort_hit_count", 128'(bus.hit_count), 0);
        chk("abort_miss_count", 128'(bus.miss_count), 0);
        sb.delete();
        ack_pat.delete();
        hits_raw   = 0;
        misses_raw = 0;
        m_vld[u_idx] = u_vld;
        m_tag[u_idx] = u_tag;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        issue(15'h3008, 1'b0, 0);           // aborted line was never written
        repeat (18) issue(15'h3009, 1'b0, 0);

        for (int t = 0; t < 70; t++) begin
            ra = {3'($urandom_range(0, 7)), 10'($urandom_range(0, 7)), 2'($urandom)};
            issue(ra, (t < 69) && ($urandom_range(0, 3) == 0), 2);
        end
        bus.cpu_req = 1'b0;

        n_wait = 0;
        while (sb.size() > 0 && n_wait < 300) begin
            @(posedge clk);
            n_wait++;
        end
        chk("drain_pending", 128'(sb.size()), 0);
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
